// File: rtl/riscv_defs.sv
// Shared RV32I definitions for the load/store unit.
// Holds funct3 width codes, the LSU state encoding, the registered request
// payload and the data memory size used for range checking.
package riscv_defs;

  localparam int unsigned NB_BYTE  = 8;
  localparam int unsigned MEM_SIZE = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Request fields captured on accept (address is kept separately, it is parameterised)
  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] store_data;
    logic [4:0]  rd;
  } lsu_req_t;

  // Access size in bytes from the low two funct3 bits
  function automatic logic [2:0] access_size(input logic [1:0] width);
    case (width)
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the LSU request/response handshake and the data memory bus.
// Signal names are seen from the LSU: i_* flow into it, o_* flow out of it.
//   slave  : the LSU itself
//   master : the environment (execute/writeback pipeline plus data memory)
interface lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_is_store;
  logic [2:0]        i_funct3;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_store_data;
  logic [4:0]        i_rd;

  logic              o_resp_valid;
  logic              i_resp_ready;
  logic [31:0]       o_load_data;
  logic [4:0]        o_rd;
  logic              o_illegal;
  logic              o_misaligned;
  logic              o_out_of_range;

  logic [ADDR_W-1:0] o_dmem_address;
  logic              o_dmem_rd_enable;
  logic              o_dmem_wr_enable;
  logic [3:0]        o_dmem_byte_en;
  logic [31:0]       o_dmem_wr_data;
  logic [31:0]       i_dmem_rd_data;
  logic              i_dmem_ack;

  modport slave (
    input  i_req_valid, i_is_store, i_funct3, i_addr, i_store_data, i_rd,
    input  i_resp_ready, i_dmem_rd_data, i_dmem_ack,
    output o_req_ready, o_resp_valid, o_load_data, o_rd,
    output o_illegal, o_misaligned, o_out_of_range,
    output o_dmem_address, o_dmem_rd_enable, o_dmem_wr_enable,
    output o_dmem_byte_en, o_dmem_wr_data
  );

  modport master (
    output i_req_valid, i_is_store, i_funct3, i_addr, i_store_data, i_rd,
    output i_resp_ready, i_dmem_rd_data, i_dmem_ack,
    input  o_req_ready, o_resp_valid, o_load_data, o_rd,
    input  o_illegal, o_misaligned, o_out_of_range,
    input  o_dmem_address, o_dmem_rd_enable, o_dmem_wr_enable,
    input  o_dmem_byte_en, o_dmem_wr_data
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational alignment and decode for one LSU access.
// Inputs : is_store, funct3, addr, store_data, rd_data (raw memory word)
// Outputs: byte_en_c, wr_data_c (lane-replicated store data),
//          load_data_c (extended load result),
//          illegal_c / misaligned_c / out_of_range_c (one-hot, prioritised)
module lsu_align
  import riscv_defs::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = MEM_SIZE
) (
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       rd_data,
  output logic [3:0]        byte_en_c,
  output logic [31:0]       wr_data_c,
  output logic [31:0]       load_data_c,
  output logic              illegal_c,
  output logic              misaligned_c,
  output logic              out_of_range_c
);

  logic [1:0]      off;
  logic [31:0]     lane;
  logic            mis_raw;
  logic            oor_raw;
  logic [ADDR_W:0] last_byte;

  assign off  = addr[1:0];
  // Shift the addressed byte/halfword down to bit 0
  assign lane = rd_data >> {off, 3'b000};

  always_comb begin
    byte_en_c      = '0;
    wr_data_c      = '0;
    load_data_c    = '0;
    illegal_c      = 1'b0;
    misaligned_c   = 1'b0;
    out_of_range_c = 1'b0;
    mis_raw        = 1'b0;
    oor_raw        = 1'b0;
    last_byte      = '0;

    if (is_store) begin
      illegal_c = !(funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      illegal_c = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

    case (funct3[1:0])
      2'b00: begin
        byte_en_c = 4'(4'b0001 << off);
        wr_data_c = {4{store_data[NB_BYTE-1:0]}};
      end
      2'b01: begin
        byte_en_c = 4'(4'b0011 << off);
        wr_data_c = {2{store_data[15:0]}};
        mis_raw   = addr[0];
      end
      default: begin
        byte_en_c = 4'b1111;
        wr_data_c = store_data;
        mis_raw   = (off != 2'b00);
      end
    endcase

    // One extra bit so an address near the top of the space cannot wrap past the limit
    last_byte = {1'b0, addr} + (ADDR_W+1)'(access_size(funct3[1:0])) - (ADDR_W+1)'(1);
    oor_raw   = (last_byte >= (ADDR_W+1)'(MEM_BYTES));

    misaligned_c   = !illegal_c && mis_raw;
    out_of_range_c = !illegal_c && !mis_raw && oor_raw;

    case (funct3)
      F3_B:    load_data_c = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   load_data_c = {24'h0, lane[7:0]};
      F3_H:    load_data_c = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   load_data_c = {16'h0, lane[15:0]};
      F3_W:    load_data_c = lane;
      default: load_data_c = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: accepts one load or store at a time, drives the data
// memory, and returns an extended load result or fault flags.
// Ports: i_clock, i_reset_n (async, active-low), bus (lsu_if.slave) carrying the
// request handshake, the response handshake and the data memory bus.
module lsu
  import riscv_defs::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = MEM_SIZE
) (
  input  logic  i_clock,
  input  logic  i_reset_n,
  lsu_if.slave  bus
);

  lsu_state_t        state;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;

  logic              req_ready_q;
  logic              resp_valid_q;
  logic [31:0]       load_data_q;
  logic              illegal_q;
  logic              misaligned_q;
  logic              oor_q;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic [3:0]        byte_en_q;
  logic [31:0]       wr_data_q;

  logic              a_is_store_c;
  logic [2:0]        a_funct3_c;
  logic [ADDR_W-1:0] a_addr_c;
  logic [31:0]       a_store_data_c;
  logic [3:0]        a_byte_en_c;
  logic [31:0]       a_wr_data_c;
  logic [31:0]       a_load_data_c;
  logic              a_illegal_c;
  logic              a_misaligned_c;
  logic              a_oor_c;
  logic              a_fault_c;

  // Decode the incoming request in IDLE, the captured one otherwise (load extraction)
  assign a_is_store_c   = (state == IDLE) ? bus.i_is_store   : req_q.is_store;
  assign a_funct3_c     = (state == IDLE) ? bus.i_funct3     : req_q.funct3;
  assign a_addr_c       = (state == IDLE) ? bus.i_addr       : addr_q;
  assign a_store_data_c = (state == IDLE) ? bus.i_store_data : req_q.store_data;

  lsu_align #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_align (
    .is_store       (a_is_store_c),
    .funct3         (a_funct3_c),
    .addr           (a_addr_c),
    .store_data     (a_store_data_c),
    .rd_data        (bus.i_dmem_rd_data),
    .byte_en_c      (a_byte_en_c),
    .wr_data_c      (a_wr_data_c),
    .load_data_c    (a_load_data_c),
    .illegal_c      (a_illegal_c),
    .misaligned_c   (a_misaligned_c),
    .out_of_range_c (a_oor_c)
  );

  assign a_fault_c = a_illegal_c || a_misaligned_c || a_oor_c;

  // Control FSM with registered outputs; reset drops memory strobes immediately
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      req_q        <= '0;
      addr_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      load_data_q  <= '0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      oor_q        <= 1'b0;
      dmem_addr_q  <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      byte_en_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req_valid) begin
            req_q.is_store   <= bus.i_is_store;
            req_q.funct3     <= bus.i_funct3;
            req_q.store_data <= bus.i_store_data;
            req_q.rd         <= bus.i_rd;
            addr_q           <= bus.i_addr;
            req_ready_q      <= 1'b0;
            if (a_fault_c) begin
              // Faults skip memory entirely and respond next cycle
              illegal_q    <= a_illegal_c;
              misaligned_q <= a_misaligned_c;
              oor_q        <= a_oor_c;
              load_data_q  <= '0;
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end else begin
              dmem_addr_q <= {bus.i_addr[ADDR_W-1:2], 2'b00};
              rd_en_q     <= !bus.i_is_store;
              wr_en_q     <= bus.i_is_store;
              byte_en_q   <= a_byte_en_c;
              wr_data_q   <= a_wr_data_c;
              state       <= ACCESS;
            end
          end
        end

        ACCESS: begin
          if (bus.i_dmem_ack) begin
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            byte_en_q    <= '0;
            load_data_q  <= req_q.is_store ? 32'h0 : a_load_data_c;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
            oor_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end
        end

        RESP: begin
          if (bus.i_resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_req_ready      = req_ready_q;
  assign bus.o_resp_valid     = resp_valid_q;
  assign bus.o_load_data      = load_data_q;
  assign bus.o_rd             = req_q.rd;
  assign bus.o_illegal        = illegal_q;
  assign bus.o_misaligned     = misaligned_q;
  assign bus.o_out_of_range   = oor_q;
  assign bus.o_dmem_address   = dmem_addr_q;
  assign bus.o_dmem_rd_enable = rd_en_q;
  assign bus.o_dmem_wr_enable = wr_en_q;
  assign bus.o_dmem_byte_en   = byte_en_q;
  assign bus.o_dmem_wr_data   = wr_data_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a byte-lane memory model with programmable ack
// delay, expected responses queued at issue and compared on retirement.
module tb_lsu;
  import riscv_defs::*;

  localparam logic [2:0] NF    = 3'b000;
  localparam logic [2:0] F_ILL = 3'b100;
  localparam logic [2:0] F_MIS = 3'b010;
  localparam logic [2:0] F_OOR = 3'b001;

  typedef struct packed {
    logic [31:0] ld;
    logic [4:0]  rd;
    logic [2:0]  fl;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(32)) bus ();

  lsu #(.ADDR_W(32), .MEM_BYTES(MEM_SIZE)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_lat = 0;
  int          cnt;
  logic [31:0] mem[256];
  logic [31:0] shadow[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory model: ack after ack_lat low cycles of an active strobe
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (bus.o_dmem_rd_enable || bus.o_dmem_wr_enable) cnt <= bus.i_dmem_ack ? 0 : cnt + 1;
    else cnt <= 0;
  end
  assign bus.i_dmem_ack     = (cnt >= ack_lat);
  assign bus.i_dmem_rd_data = mem[bus.o_dmem_address[9:2]];

  always @(posedge clk) begin
    if (rst_n && bus.o_dmem_wr_enable && bus.i_dmem_ack)
      for (int b = 0; b < 4; b++)
        if (bus.o_dmem_byte_en[b])
          mem[bus.o_dmem_address[9:2]][b*8 +: 8] <= bus.o_dmem_wr_data[b*8 +: 8];
  end

  // Response monitor: pop and compare on each retirement
  always @(negedge clk) begin
    if (rst_n && bus.o_resp_valid && bus.i_resp_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("load_data", bus.o_load_data, mon_e.ld);
        check("rd", 32'(bus.o_rd), 32'(mon_e.rd));
        check("flags", 32'({bus.o_illegal, bus.o_misaligned, bus.o_out_of_range}), 32'(mon_e.fl));
      end
    end
  end

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   ref_be = 4'(4'b0001 << off);
      2'b01:   ref_be = off[1] ? 4'b1100 : 4'b0011;
      default: ref_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   ref_wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   ref_wd = {d[15:0], d[15:0]};
      default: ref_wd = d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    ref_load = {{24{b[7]}}, b};
      F3_BU:   ref_load = {24'h0, b};
      F3_H:    ref_load = {{16{h[15]}}, h};
      F3_HU:   ref_load = {16'h0, h};
      F3_W:    ref_load = w;
      default: ref_load = 32'h0;
    endcase
  endfunction

  // Issue one request, check strobes/latency/backpressure, wait for retirement
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic [4:0] rd,
                      input logic [31:0] exp_ld, input logic [2:0] exp_fl,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input int exp_lat, input int hold);
    int         n;
    logic [5:0] strb0;
    n = 0;
    while (!bus.o_req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready", 32'(bus.o_req_ready), 32'd1);
    sb.push_back(exp_t'{exp_ld, rd, exp_fl});
    bus.i_req_valid  = 1'b1;
    bus.i_is_store   = st;
    bus.i_funct3     = f3;
    bus.i_addr       = a;
    bus.i_store_data = d;
    bus.i_rd         = rd;
    bus.i_resp_ready = (hold == 0);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    if (exp_fl != NF) begin
      check("fault_strobes", 32'({bus.o_dmem_rd_enable, bus.o_dmem_wr_enable}), 32'd0);
    end else begin
      check("rd_en", 32'(bus.o_dmem_rd_enable), 32'(!st));
      check("wr_en", 32'(bus.o_dmem_wr_enable), 32'(st));
      check("byte_en", 32'(bus.o_dmem_byte_en), 32'(exp_be));
      check("dmem_addr", bus.o_dmem_address, {a[31:2], 2'b00});
      if (st) check("wr_data", bus.o_dmem_wr_data, exp_wd);
    end
    strb0 = {bus.o_dmem_rd_enable, bus.o_dmem_wr_enable, bus.o_dmem_byte_en};
    n = 1;
    while (!bus.o_resp_valid && n < 50) begin
      check("busy_ready", 32'(bus.o_req_ready), 32'd0);
      check("strobe_hold", 32'({bus.o_dmem_rd_enable, bus.o_dmem_wr_enable, bus.o_dmem_byte_en}), 32'(strb0));
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("resp_strobes", 32'({bus.o_dmem_rd_enable, bus.o_dmem_wr_enable, bus.o_dmem_byte_en}), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.o_resp_valid), 32'd1);
      check("bp_data", bus.o_load_data, exp_ld);
      check("bp_ready", 32'(bus.o_req_ready), 32'd0);
    end
    bus.i_resp_ready = 1'b1;
    @(posedge clk); #1;
    check("retired", 32'({bus.o_resp_valid, bus.o_req_ready}), 32'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, d, ld, wd;
    logic [3:0]  be;
    int          sz, al;

    bus.i_req_valid  = 1'b0;
    bus.i_is_store   = 1'b0;
    bus.i_funct3     = 3'b000;
    bus.i_addr       = 32'h0;
    bus.i_store_data = 32'h0;
    bus.i_rd         = 5'd0;
    bus.i_resp_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.o_req_ready), 32'd1);
    check("rst_resp", 32'({bus.o_resp_valid, bus.o_illegal, bus.o_misaligned, bus.o_out_of_range}), 32'd0);
    check("rst_load_data", bus.o_load_data, 32'd0);
    check("rst_rd", 32'(bus.o_rd), 32'd0);
    check("rst_strobes", 32'({bus.o_dmem_rd_enable, bus.o_dmem_wr_enable, bus.o_dmem_byte_en}), 32'd0);
    check("rst_addr", bus.o_dmem_address, 32'd0);
    check("rst_wdata", bus.o_dmem_wr_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stores and lane extraction
    send(1'b1, F3_W,  32'h10, 32'hDEADBEEF, 5'd1,  32'h0,        NF, 4'hF,    32'hDEADBEEF, 2, 0);
    send(1'b0, F3_W,  32'h10, 32'h0,        5'd2,  32'hDEADBEEF, NF, 4'hF,    32'h0,        2, 0);
    send(1'b1, F3_W,  32'h10, 32'h0,        5'd3,  32'h0,        NF, 4'hF,    32'h0,        2, 0);
    send(1'b1, F3_B,  32'h13, 32'h000000A5, 5'd4,  32'h0,        NF, 4'b1000, 32'hA5A5A5A5, 2, 0);
    send(1'b0, F3_W,  32'h10, 32'h0,        5'd5,  32'hA5000000, NF, 4'hF,    32'h0,        2, 0);
    send(1'b0, F3_B,  32'h13, 32'h0,        5'd6,  32'hFFFFFFA5, NF, 4'b1000, 32'h0,        2, 0);
    send(1'b0, F3_BU, 32'h13, 32'h0,        5'd7,  32'h000000A5, NF, 4'b1000, 32'h0,        2, 0);
    send(1'b1, F3_W,  32'h20, 32'h80010000, 5'd8,  32'h0,        NF, 4'hF,    32'h80010000, 2, 0);
    send(1'b0, F3_H,  32'h22, 32'h0,        5'd9,  32'hFFFF8001, NF, 4'b1100, 32'h0,        2, 0);
    send(1'b0, F3_HU, 32'h22, 32'h0,        5'd10, 32'h00008001, NF, 4'b1100, 32'h0,        2, 0);
    send(1'b0, F3_BU, 32'h23, 32'h0,        5'd11, 32'h00000080, NF, 4'b1000, 32'h0,        2, 0);
    send(1'b0, F3_B,  32'h22, 32'h0,        5'd12, 32'h00000001, NF, 4'b0100, 32'h0,        2, 0);
    send(1'b1, F3_H,  32'h12, 32'h0000BEEF, 5'd13, 32'h0,        NF, 4'b1100, 32'hBEEFBEEF, 2, 0);

    // Fault decode and priority
    send(1'b0, F3_W,   32'h06, 32'h0, 5'd14, 32'h0, F_MIS, 4'h0, 32'h0, 1, 0);
    send(1'b0, 3'b011, 32'h06, 32'h0, 5'd15, 32'h0, F_ILL, 4'h0, 32'h0, 1, 0);
    send(1'b1, 3'b011, 32'h10, 32'h0, 5'd16, 32'h0, F_ILL, 4'h0, 32'h0, 1, 0);
    send(1'b1, 3'b100, 32'h10, 32'h0, 5'd17, 32'h0, F_ILL, 4'h0, 32'h0, 1, 0);
    send(1'b0, 3'b110, 32'h10, 32'h0, 5'd18, 32'h0, F_ILL, 4'h0, 32'h0, 1, 0);
    send(1'b0, F3_H,   32'h21, 32'h0, 5'd19, 32'h0, F_MIS, 4'h0, 32'h0, 1, 0);
    send(1'b1, F3_H,   32'h23, 32'h0, 5'd20, 32'h0, F_MIS, 4'h0, 32'h0, 1, 0);

    // Top-of-memory boundary
    send(1'b1, F3_W,  32'h3FC, 32'h12345678, 5'd21, 32'h0,        NF, 4'hF,    32'h12345678, 2, 0);
    send(1'b0, F3_W,  32'h3FC, 32'h0,        5'd22, 32'h12345678, NF, 4'hF,    32'h0,        2, 0);
    send(1'b0, F3_H,  32'h3FE, 32'h0,        5'd23, 32'h00001234, NF, 4'b1100, 32'h0,        2, 0);
    send(1'b0, F3_B,  32'h3FF, 32'h0,        5'd24, 32'h00000012, NF, 4'b1000, 32'h0,        2, 0);
    send(1'b1, F3_B,  32'h3FF, 32'h0000009A, 5'd25, 32'h0,        NF, 4'b1000, 32'h9A9A9A9A, 2, 0);
    send(1'b0, F3_B,  32'h3FF, 32'h0,        5'd26, 32'hFFFFFF9A, NF, 4'b1000, 32'h0,        2, 0);
    send(1'b0, F3_W,  32'h400, 32'h0,        5'd27, 32'h0, F_OOR, 4'h0, 32'h0, 1, 0);
    send(1'b0, F3_H,  32'h3FF, 32'h0,        5'd28, 32'h0, F_MIS, 4'h0, 32'h0, 1, 0);
    send(1'b0, F3_B,  32'h400, 32'h0,        5'd29, 32'h0, F_OOR, 4'h0, 32'h0, 1, 0);
    send(1'b0, F3_W,  32'hFFFFFFFC, 32'h0,   5'd30, 32'h0, F_OOR, 4'h0, 32'h0, 1, 0);
    send(1'b1, F3_W,  32'h400, 32'h0,        5'd31, 32'h0, F_OOR, 4'h0, 32'h0, 1, 0);
    send(1'b0, 3'b111, 32'h401, 32'h0,       5'd1,  32'h0, F_ILL, 4'h0, 32'h0, 1, 0);

    // Slow memory plus response backpressure
    ack_lat = 3;
    send(1'b0, F3_W, 32'h20, 32'h0, 5'd2, 32'h80010000, NF, 4'hF, 32'h0, 5, 2);
    ack_lat = 0;

    // Reset during the ACCESS cycle of a store must not commit it
    send(1'b1, F3_W, 32'h40, 32'h11223344, 5'd3, 32'h0, NF, 4'hF, 32'h11223344, 2, 0);
    ack_lat = 5;
    bus.i_req_valid  = 1'b1;
    bus.i_is_store   = 1'b1;
    bus.i_funct3     = F3_W;
    bus.i_addr       = 32'h40;
    bus.i_store_data = 32'hCAFEF00D;
    bus.i_rd         = 5'd4;
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    check("rst_pre_wr_en", 32'(bus.o_dmem_wr_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_strobes", 32'({bus.o_dmem_rd_enable, bus.o_dmem_wr_enable, bus.o_dmem_byte_en}), 32'd0);
    check("rst_async_ready", 32'(bus.o_req_ready), 32'd1);
    check("rst_async_resp", 32'(bus.o_resp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    ack_lat = 0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'({bus.o_req_ready, bus.o_resp_valid}), 32'b10);
    send(1'b0, F3_W, 32'h40, 32'h0, 5'd5, 32'h11223344, NF, 4'hF, 32'h0, 2, 0);

    // Randomised mix over a 64-byte window against a shadow model
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      shadow[w] = d;
      send(1'b1, F3_W, 32'(w * 4), d, 5'(w), 32'h0, NF, 4'hF, d, 2, 0);
    end
    for (int k = 0; k < 40; k++) begin
      st = 1'($urandom_range(0, 1));
      sz = int'($urandom_range(0, 2));
      f3 = {1'b0, sz[1:0]};
      if (!st && sz < 2 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
      a = 32'($urandom_range(0, 63));
      if (sz == 1) a[0] = 1'b0;
      if (sz == 2) a[1:0] = 2'b00;
      d  = $urandom;
      al = int'($urandom_range(0, 2));
      ack_lat = al;
      be = ref_be(f3, a[1:0]);
      wd = ref_wd(f3, d);
      if (st) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
        ld = 32'h0;
      end else begin
        ld = ref_load(shadow[a[5:2]], f3, a[1:0]);
      end
      send(st, f3, a, d, 5'(k), ld, NF, be, wd, 2 + al, 0);
    end
    ack_lat = 0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
